// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // Action taken on IF/ID and PC at a RUN-state edge, highest priority last.
   typedef enum logic [1:0] {
      ACT_ADVANCE = 2'd0,
      ACT_HOLD    = 2'd1,
      ACT_HALT    = 2'd2,
      ACT_BRANCH  = 2'd3
   } fetch_act_t;

   localparam logic [XLEN-1:0] ARM_NOP       = 32'hE1A0_0000;
   localparam logic [XLEN-1:0] PC_STEP       = 32'd4;
   localparam logic [XLEN-1:0] PC_READ_OFS   = 32'd8;
   localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: fetch drives the PC and read enable, memory returns the word.
interface fetch_unit_if;
   import fetch_pkg::*;

   logic [XLEN-1:0] imem_pc;
   logic            imem_rd_en;
   logic [XLEN-1:0] imem_instr;

   modport master (output imem_pc, output imem_rd_en, input imem_instr);
   modport slave  (input imem_pc, input imem_rd_en, output imem_instr);
endinterface

// File: rtl/fetch_unit_pc_next_mux.sv
// Priority selection of the next PC and IF/ID action in RUN: branch > halt > stall > advance.
module pc_next_mux
   import fetch_pkg::*;
(
   input  logic [XLEN-1:0] pc_q,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            halt_req,
   output fetch_act_t      act_c,
   output logic [XLEN-1:0] pc_next_c
);

   always_comb begin
      act_c     = ACT_ADVANCE;
      pc_next_c = pc_q + PC_STEP;
      if (branch_taken) begin
         act_c     = ACT_BRANCH;
         pc_next_c = branch_target & PC_ALIGN_MASK;
      end else if (halt_req) begin
         act_c     = ACT_HALT;
         pc_next_c = pc_q;
      end else if (stall) begin
         act_c     = ACT_HOLD;
         pc_next_c = pc_q;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID register.
// Optional FETCH_RANGE_CHK_EN adds imem_fault and halts on fetches beyond the memory.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = ARM_NOP
`ifdef FETCH_RANGE_CHK_EN
   , parameter int unsigned IMEM_ADDR_W = 8
`endif
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            halt_req,
   fetch_unit_if.master    imem,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus8,
   output logic            id_valid,
   output logic            halted
`ifdef FETCH_RANGE_CHK_EN
   , output logic          imem_fault
`endif
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc_q;
   fetch_act_t      act_c;
   logic [XLEN-1:0] pc_next_c;
   logic            fault_c;

   pc_next_mux u_pc_next_mux (
      .pc_q          (pc_q),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt_req      (halt_req),
      .act_c         (act_c),
      .pc_next_c     (pc_next_c)
   );

`ifdef FETCH_RANGE_CHK_EN
   assign fault_c = |(pc_q >> (IMEM_ADDR_W + 2));

   // Sticky fault, raised only where a fetch would actually be consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         imem_fault <= 1'b0;
      end else if (fault_c && (state == BOOT || (state == RUN && act_c == ACT_ADVANCE))) begin
         imem_fault <= 1'b1;
      end
   end
`else
   assign fault_c = 1'b0;
`endif

   assign imem.imem_pc = pc_q;

   always_comb begin
      imem.imem_rd_en = 1'b0;
      if (!rst) begin
         case (state)
            BOOT:    imem.imem_rd_en = 1'b1;
            RUN:     imem.imem_rd_en = !stall;
            default: imem.imem_rd_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_VEC;
         state       <= BOOT;
         id_instr    <= NOP_INSTR;
         id_pc       <= '0;
         id_pc_plus8 <= PC_READ_OFS;
         id_valid    <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               if (fault_c) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               case (act_c)
                  ACT_BRANCH: begin
                     pc_q     <= pc_next_c;
                     id_instr <= NOP_INSTR;
                     id_valid <= 1'b0;
                  end
                  ACT_HALT: begin
                     state    <= HALT;
                     halted   <= 1'b1;
                     id_instr <= NOP_INSTR;
                     id_valid <= 1'b0;
                  end
                  ACT_ADVANCE: begin
                     if (fault_c) begin
                        state    <= HALT;
                        halted   <= 1'b1;
                        id_instr <= NOP_INSTR;
                        id_valid <= 1'b0;
                     end else begin
                        id_instr    <= imem.imem_instr;
                        id_pc       <= pc_q;
                        id_pc_plus8 <= pc_q + PC_READ_OFS;
                        id_valid    <= 1'b1;
                        pc_q        <= pc_next_c;
                     end
                  end
                  default: ;
               endcase
            end
            default: state <= HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a transaction-level fetch model.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'hE1A0_0000;
`ifdef FETCH_RANGE_CHK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        halt_req;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus8;
   logic        id_valid;
   logic        halted;
   logic        imem_fault;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_VEC (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt_req      (halt_req),
      .imem          (bus.master),
      .id_instr      (id_instr),
      .id_pc         (id_pc),
      .id_pc_plus8   (id_pc_plus8),
      .id_valid      (id_valid),
      .halted        (halted)
`ifdef FETCH_RANGE_CHK_EN
      , .imem_fault  (imem_fault)
`endif
   );

`ifndef FETCH_RANGE_CHK_EN
   assign imem_fault = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] salt = 32'h0;

   // Memory contents are a function of the address; read registered on the falling edge.
   always @(negedge clk) begin
      if (bus.imem_rd_en) bus.imem_instr <= bus.imem_pc ^ salt;
   end

   // Reference model: what the fetch stage should present, in program terms.
   logic [31:0] m_pc, m_instr, m_idpc;
   logic        m_valid, m_halt, m_boot, m_fault;

   function automatic bit out_of_range(input logic [31:0] a);
      return (a >> 10) != 32'd0;
   endfunction

   function logic [130:0] dut_vec();
      return {bus.imem_pc, id_instr, id_pc, id_pc_plus8, id_valid, halted, imem_fault};
   endfunction

   function logic [130:0] model_vec();
      return {m_pc, m_instr, m_idpc, m_idpc + 32'd8, m_valid, m_halt, m_fault};
   endfunction

   task automatic do_reset(output logic rd_o);
      rst = 1'b1;
      stall = 1'($urandom);
      branch_taken = 1'($urandom);
      branch_target = $urandom;
      halt_req = 1'($urandom);
      #1 rd_o = bus.imem_rd_en;
      @(posedge clk);
      m_pc = 32'h0; m_instr = NOP; m_idpc = 32'h0;
      m_valid = 1'b0; m_halt = 1'b0; m_boot = 1'b1; m_fault = 1'b0;
      #1 rst = 1'b0;
   endtask

   task automatic step(input logic s, input logic b, input logic [31:0] t, input logic h,
                       output logic rd_o, output logic rd_e);
      stall = s; branch_taken = b; branch_target = t; halt_req = h; rst = 1'b0;
      rd_e = m_boot ? 1'b1 : (m_halt ? 1'b0 : !s);
      #1 rd_o = bus.imem_rd_en;
      @(posedge clk);
      if (m_boot) begin
         m_boot = 1'b0;
         if (RANGE_CHK && out_of_range(m_pc)) begin
            m_halt = 1'b1; m_fault = 1'b1;
         end
      end else if (!m_halt) begin
         if (b) begin
            m_pc = {t[31:2], 2'b00}; m_instr = NOP; m_valid = 1'b0;
         end else if (h) begin
            m_halt = 1'b1; m_instr = NOP; m_valid = 1'b0;
         end else if (!s) begin
            if (RANGE_CHK && out_of_range(m_pc)) begin
               m_halt = 1'b1; m_fault = 1'b1; m_instr = NOP; m_valid = 1'b0;
            end else begin
               m_instr = m_pc ^ salt; m_idpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      logic ro, re;
      salt = 32'h0;
      do_reset(ro);
      n_checks++;
      if ({ro, dut_vec()} !== {1'b0, model_vec()}) begin
         n_fail++;
         $display("FAIL reset_state: got %h required %h", {ro, dut_vec()}, {1'b0, model_vec()});
      end
      // BOOT ignores branch, halt and stall and still reads.
      step(1'b1, 1'b1, 32'h80, 1'b1, ro, re);
      n_checks++;
      if ({ro, dut_vec()} !== {re, model_vec()} || ro !== 1'b1) begin
         n_fail++;
         $display("FAIL boot_cycle: got %h required %h", {ro, dut_vec()}, {1'b1, model_vec()});
      end
   endtask

   task automatic test_sequential();
      logic ro, re, ro0;
      do_reset(ro0);
      step(1'b0, 1'b0, 32'h0, 1'b0, ro, re);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, ro, re);
         n_checks++;
         if ({ro, dut_vec()} !== {re, model_vec()} || id_pc !== 32'(4 * i)
             || id_instr !== 32'(4 * i) || id_pc_plus8 !== 32'(4 * i + 8) || id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sequential[%0d]: got %h required %h", i, {ro, dut_vec()}, {re, model_vec()});
         end
      end
   endtask

   task automatic test_stall();
      logic ro, re;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0, ro, re);
         n_checks++;
         if ({ro, dut_vec()} !== {re, model_vec()} || bus.imem_pc !== 32'h10 || ro !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got %h required %h", i, {ro, dut_vec()}, {re, model_vec()});
         end
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, ro, re);
      n_checks++;
      if (id_pc !== 32'h10 || id_instr !== 32'h10 || id_valid !== 1'b1 || bus.imem_pc !== 32'h14) begin
         n_fail++;
         $display("FAIL stall_release: got id_pc=%h id_instr=%h required 10/10", id_pc, id_instr);
      end
   endtask

   task automatic test_branch_stall();
      logic ro, re;
      step(1'b1, 1'b1, 32'h40, 1'b0, ro, re);
      n_checks++;
      if (bus.imem_pc !== 32'h40 || id_valid !== 1'b0 || id_instr !== NOP
          || {ro, dut_vec()} !== {re, model_vec()}) begin
         n_fail++;
         $display("FAIL branch_under_stall: got %h required %h", {ro, dut_vec()}, {re, model_vec()});
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, ro, re);
      n_checks++;
      if (id_pc !== 32'h40 || id_valid !== 1'b1 || {ro, dut_vec()} !== {re, model_vec()}) begin
         n_fail++;
         $display("FAIL branch_first_fetch: got id_pc=%h required 00000040", id_pc);
      end
   endtask

   task automatic test_wrap();
      logic ro, re;
      step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, ro, re);
      n_checks++;
      if (bus.imem_pc !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL branch_align: got pc=%h required fffffffc", bus.imem_pc);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, ro, re);
      step(1'b0, 1'b0, 32'h0, 1'b0, ro, re);
      n_checks++;
      if (id_pc !== 32'h0 || id_pc_plus8 !== 32'h8 || bus.imem_pc !== 32'h4) begin
         n_fail++;
         $display("FAIL pc_wrap: got id_pc=%h pc=%h required 00000000/00000004", id_pc, bus.imem_pc);
      end
   endtask

   task automatic test_halt();
      logic ro, re;
      step(1'b0, 1'b0, 32'h0, 1'b1, ro, re);
      for (int i = 0; i < 10; i++) begin
         step(1'($urandom), 1'($urandom), $urandom, 1'($urandom), ro, re);
         n_checks++;
         if ({ro, dut_vec()} !== {re, model_vec()} || halted !== 1'b1 || ro !== 1'b0 || id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_hold[%0d]: got %h required %h", i, {ro, dut_vec()}, {re, model_vec()});
         end
      end
      do_reset(ro);
      step(1'b1, 1'b0, 32'h0, 1'b0, ro, re);
      n_checks++;
      if (halted !== 1'b0 || bus.imem_pc !== 32'h0 || ro !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_reset: got halted=%b pc=%h rd=%b required 0/00000000/1", halted, bus.imem_pc, ro);
      end
   endtask

   task automatic test_random();
      logic ro, re;
      logic [31:0] t;
      salt = $urandom;
      do_reset(ro);
      for (int i = 0; i < 400; i++) begin
         if (m_halt && $urandom_range(0, 5) == 0) begin
            salt = $urandom;
            do_reset(ro);
            n_checks++;
            if ({ro, dut_vec()} !== {1'b0, model_vec()}) begin
               n_fail++;
               $display("FAIL random_reset[%0d]: got %h required %h", i, {ro, dut_vec()}, {1'b0, model_vec()});
            end
         end
         t = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
         step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t, $urandom_range(0, 59) == 0, ro, re);
         n_checks++;
         if ({ro, dut_vec()} !== {re, model_vec()}) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h required %h", i, {ro, dut_vec()}, {re, model_vec()});
         end
      end
   endtask

   task automatic test_range();
      logic ro, re;
      salt = 32'h0;
      do_reset(ro);
      step(1'b0, 1'b0, 32'h0, 1'b0, ro, re);
      step(1'b0, 1'b1, 32'h400, 1'b0, ro, re);
      step(1'b0, 1'b0, 32'h0, 1'b0, ro, re);
      n_checks++;
      if (imem_fault !== 1'b1 || halted !== 1'b1 || id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL range_fault: got fault=%b halted=%b required 1/1", imem_fault, halted);
      end
      do_reset(ro);
      step(1'b0, 1'b0, 32'h0, 1'b0, ro, re);
      step(1'b0, 1'b1, 32'h3FC, 1'b0, ro, re);
      step(1'b0, 1'b0, 32'h0, 1'b0, ro, re);
      n_checks++;
      if (imem_fault !== 1'b0 || halted !== 1'b0 || id_pc !== 32'h3FC || id_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL range_edge: got fault=%b halted=%b id_pc=%h required 0/0/000003fc",
                  imem_fault, halted, id_pc);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; halt_req = 1'b0;
      test_reset();
      test_sequential();
      test_stall();
      test_branch_stall();
      test_wrap();
      test_halt();
      test_random();
      if (RANGE_CHK) test_range();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
